audio_i2s_rx: RTL and testbench

Receive-side counterpart of the board's I2S speaker path. Deserializes the codec ADC stream (audio_sdout) using externally supplied LRCK/SCK, and presents one 16-bit left/right sample pair per audio frame with a single-cycle valid strobe. It sits beside speaker_control in the sound subsystem, feeding captured audio, such as microphone input or loopback checking, to game logic.

---
 rtl/audio_pkg.sv | 17 +
 rtl/sync_2ff.sv | 28 ++
 rtl/audio_i2s_rx.sv | 188 ++++++++++++++++++
 tb/tb_audio_i2s_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio path: word/slot geometry, channel
// encoding on LRCK and receive-FSM state encoding.
package audio_pkg;

  localparam int DATA_W = 16;
  localparam int SLOT_W = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

endpackage : audio_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample their inputs before
  // either updates, so the chain really is two flops deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/audio_i2s_rx.sv
// I2S receiver: oversamples LRCK/SCK/SDATA with clk, deserializes 16-bit MSB-first
// words with the one-slot I2S delay and publishes left/right pairs together.
module audio_i2s_rx #(
  parameter int DATA_W = audio_pkg::DATA_W,
  parameter int SLOT_W = audio_pkg::SLOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              audio_lrck,
  input  logic              audio_sck,
  input  logic              audio_sdout,
  output logic [DATA_W-1:0] audio_left,
  output logic [DATA_W-1:0] audio_right,
  output logic              sample_valid,
  output logic              frame_err
);

  import audio_pkg::*;

  localparam int SLOT_CNT_W = $clog2(2 * SLOT_W);
  localparam logic [SLOT_CNT_W-1:0] SLOT_MAX  = '1;
  localparam logic [SLOT_CNT_W-1:0] WORD_SLOT = SLOT_CNT_W'(DATA_W);

  logic [2:0] sync_in;
  logic [2:0] sync_out;
  logic       sck_s;
  logic       lrck_s;
  logic       sdat_s;

  assign sync_in = {audio_sdout, audio_lrck, audio_sck};

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sync_in),
    .q_o   (sync_out)
  );

  assign sck_s  = sync_out[0];
  assign lrck_s = sync_out[1];
  assign sdat_s = sync_out[2];

  logic                  sck_prev_q;
  logic                  sck_rise;
  logic                  lrck_prev_q;
  logic                  lrck_diff;
  logic [SLOT_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  // The last word bit is taken straight from sdat_s at capture time, so only
  // the first DATA_W-1 bits need to be held.
  logic [DATA_W-2:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     word_d;
  logic                  in_word;
  logic                  word_done;
  logic                  short_half;

  rx_state_e state_q, state_d;
  logic      cap_left;
  logic      cap_right;
  logic      err_det;

  logic [DATA_W-1:0] left_hold_q;
  logic [DATA_W-1:0] right_hold_q;
  logic              left_ok_q;
  logic              pub_q;
  logic              err_q;
  logic [DATA_W-1:0] audio_left_q;
  logic [DATA_W-1:0] audio_right_q;
  logic              sample_valid_q;
  logic              frame_err_q;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign lrck_diff = lrck_s != lrck_prev_q;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (lrck_diff) begin
      slot_cnt_d = '0;
    end else if (slot_cnt_q != SLOT_MAX) begin
      slot_cnt_d = slot_cnt_q + SLOT_CNT_W'(1);
    end
  end

  assign in_word    = (slot_cnt_d != '0) && (slot_cnt_d <= WORD_SLOT);
  assign shift_d    = {shift_q[DATA_W-3:0], sdat_s};
  assign word_d     = {shift_q, sdat_s};
  assign word_done  = sck_rise && !lrck_diff && (slot_cnt_d == WORD_SLOT);
  assign short_half = slot_cnt_q < WORD_SLOT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // A short half-frame drops back to SYNC; the edge that flagged it is not
  // allowed to also start a new left word.
  always_comb begin
    state_d = state_q;
    if (sck_rise && lrck_diff) begin
      case (state_q)
        SYNC:    if (lrck_s == CH_LEFT) state_d = LEFT;
        LEFT:    state_d = short_half ? SYNC : RIGHT;
        RIGHT:   state_d = short_half ? SYNC : LEFT;
        default: state_d = SYNC;
      endcase
    end
  end

  always_comb begin
    cap_left  = 1'b0;
    cap_right = 1'b0;
    err_det   = 1'b0;
    case (state_q)
      LEFT: begin
        cap_left = word_done;
        err_det  = sck_rise && lrck_diff && short_half;
      end
      RIGHT: begin
        cap_right = word_done;
        err_det   = sck_rise && lrck_diff && short_half;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_q  <= 1'b0;
      lrck_prev_q <= CH_LEFT;
      slot_cnt_q  <= '0;
      shift_q     <= '0;
    end else begin
      sck_prev_q <= sck_s;
      if (sck_rise) begin
        lrck_prev_q <= lrck_s;
        slot_cnt_q  <= slot_cnt_d;
        if (in_word) shift_q <= shift_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_ok_q    <= 1'b0;
      pub_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pub_q <= cap_right && left_ok_q;
      err_q <= err_det;
      if (cap_left) begin
        left_hold_q <= word_d;
        left_ok_q   <= 1'b1;
      end else if (err_det || (cap_right && left_ok_q)) begin
        left_ok_q <= 1'b0;
      end
      if (cap_right) right_hold_q <= word_d;
    end
  end

  // Output stage: the pair only moves in the cycle sample_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_left_q   <= '0;
      audio_right_q  <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      sample_valid_q <= pub_q;
      frame_err_q    <= err_q;
      if (pub_q) begin
        audio_left_q  <= left_hold_q;
        audio_right_q <= right_hold_q;
      end
    end
  end

  assign audio_left   = audio_left_q;
  assign audio_right  = audio_right_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;

endmodule : audio_i2s_rx

// File: tb/tb_audio_i2s_rx.sv
// Self-checking bench for audio_i2s_rx: an I2S transmitter model drives the DUT and
// a half-frame-level reference model predicts published pairs and frame errors.
`timescale 1ns/1ps
module tb_audio_i2s_rx;

  localparam int DW      = 16;
  localparam int HALF_NS = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          audio_lrck;
  logic          audio_sck;
  logic          audio_sdout;
  logic [DW-1:0] audio_left;
  logic [DW-1:0] audio_right;
  logic          sample_valid;
  logic          frame_err;

  audio_i2s_rx #(.DATA_W(16), .SLOT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .audio_sdout  (audio_sdout),
    .audio_left   (audio_left),
    .audio_right  (audio_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  int    cmp_cnt = 0;
  int    mis_cnt = 0;
  pair_t got_q[$];
  pair_t exp_q[$];
  int    got_err   = 0;
  int    exp_err   = 0;
  int    got_valid = 0;
  int    both_viol = 0;
  int    chg_viol  = 0;
  time   last_valid_t = 0;
  time   last_r16_t   = 0;
  logic [2*DW-1:0] prev_out = '0;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_q.push_back({audio_left, audio_right});
      got_valid++;
      last_valid_t = $time;
    end
    if (frame_err === 1'b1) got_err++;
    if (sample_valid === 1'b1 && frame_err === 1'b1) both_viol++;
    if (rst_n === 1'b1 && sample_valid !== 1'b1 && {audio_left, audio_right} !== prev_out)
      chg_viol++;
    prev_out = {audio_left, audio_right};
  end

  // Reference model, one call per LRCK half-frame: mode 0 = unsynced,
  // 1 = in a left half, 2 = in a right half.
  bit            m_prev_ch;
  int            m_mode;
  int            m_last_len;
  logic [DW-1:0] m_left;
  bit            m_have_left;
  pair_t         m_last_pair = '0;

  task automatic model_reset();
    m_prev_ch   = 1'b0;
    m_mode      = 0;
    m_last_len  = 0;
    m_have_left = 1'b0;
    m_last_pair = '0;
  endtask

  task automatic model_half(input bit ch, input logic [DW-1:0] w, input int len);
    if (ch == m_prev_ch) begin
      m_last_len += len;
      return;
    end
    if (m_mode != 0 && m_last_len <= DW) begin
      exp_err++;
      m_mode      = 0;
      m_have_left = 1'b0;
    end else if (m_mode == 0) begin
      if (ch == 1'b0) m_mode = 1;
    end else begin
      m_mode = ch ? 2 : 1;
    end
    m_prev_ch  = ch;
    m_last_len = len;
    if (len > DW) begin
      if (m_mode == 1) begin
        m_left      = w;
        m_have_left = 1'b1;
      end else if (m_mode == 2 && m_have_left) begin
        m_last_pair = {m_left, w};
        exp_q.push_back(m_last_pair);
        m_have_left = 1'b0;
      end
    end
  endtask

  // Slot 0 carries the previous word's LSB (random here), slots 1..16 the word
  // MSB first, later slots random filler.
  task automatic send_half(input bit ch, input logic [DW-1:0] w, input int len);
    model_half(ch, w, len);
    for (int k = 0; k < len; k++) begin
      audio_sck   = 1'b0;
      audio_lrck  = ch;
      audio_sdout = (k >= 1 && k <= DW) ? w[DW-k] : 1'($urandom);
      #HALF_NS;
      audio_sck = 1'b1;
      if (ch && k == DW) last_r16_t = $time;
      #HALF_NS;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_half(1'b0, l, 32);
    send_half(1'b1, r, 32);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pairs(input string tag);
    #200;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_pair"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_err"}, got_err, exp_err);
  endtask

  int   v_snap;
  int   e_snap;
  int   lat;
  int   len_l;
  int   len_r;

  initial begin
    rst_n       = 1'b0;
    audio_lrck  = 1'b0;
    audio_sck   = 1'b0;
    audio_sdout = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_left",  audio_left,   '0);
    check("rst_right", audio_right,  '0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_err",   frame_err,    1'b0);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Start mid right channel, then loopback-style frames.
    send_half(1'b1, 16'(($urandom)), 20);
    repeat (3) send_frame(16'hA5C3, 16'h5A3C);
    #200;
    check("startup_valid_cnt", got_valid, 3);
    check("lb_left",  audio_left,  16'hA5C3);
    check("lb_right", audio_right, 16'h5A3C);
    check_pairs("loopback");

    send_frame(16'h8001, 16'h0001);
    check_pairs("bitorder");
    lat = int'(last_valid_t - last_r16_t);
    check("latency_window", (lat >= 25 && lat <= 55), 1'b1);

    // Short left half (10 slots), then a clean frame.
    v_snap = got_valid;
    send_half(1'b0, 16'(($urandom)), 10);
    send_half(1'b1, 16'(($urandom)), 32);
    send_frame(16'h1111, 16'h2222);
    check_pairs("short_left");
    check("short_left_valid_cnt", got_valid - v_snap, 1);

    // Short right half: the offending 1->0 edge must not start a left word.
    send_half(1'b0, 16'(($urandom)), 32);
    send_half(1'b1, 16'(($urandom)), 12);
    send_half(1'b0, 16'h3333, 32);
    send_half(1'b1, 16'h4444, 32);
    send_frame(16'h5555, 16'h6666);
    check_pairs("short_right");

    for (int f = 0; f < 12; f++) begin
      len_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 40)) : 32;
      len_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 40)) : 32;
      send_half(1'b0, 16'(($urandom)), len_l);
      send_half(1'b1, 16'(($urandom)), len_r);
    end
    send_frame(16'(($urandom)), 16'(($urandom)));
    send_frame(16'(($urandom)), 16'(($urandom)));
    check_pairs("random");

    // SCK stall for 1000 clk cycles.
    v_snap = got_valid;
    e_snap = got_err;
    #10000;
    check("stall_valid", got_valid - v_snap, 0);
    check("stall_err",   got_err - e_snap,   0);
    check("stall_out",   {audio_left, audio_right}, m_last_pair);
    send_frame(16'(($urandom)), 16'(($urandom)));
    check_pairs("after_stall");

    // LRCK held for 100 slots in each channel; filler beyond slot 16 is random.
    send_half(1'b0, 16'(($urandom)), 100);
    send_half(1'b1, 16'(($urandom)), 32);
    send_half(1'b0, 16'(($urandom)), 32);
    send_half(1'b1, 16'(($urandom)), 100);
    send_frame(16'(($urandom)), 16'(($urandom)));
    check_pairs("lrck_hold");

    // Reset during right slot 8.
    send_half(1'b0, 16'(($urandom)), 32);
    send_half(1'b1, 16'(($urandom)), 9);
    #23 rst_n = 1'b0;
    model_reset();
    #10;
    check("midrst_left",  audio_left,   '0);
    check("midrst_right", audio_right,  '0);
    check("midrst_valid", sample_valid, 1'b0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    send_half(1'b1, 16'(($urandom)), 32);
    send_frame(16'hBEEF, 16'hCAFE);
    check_pairs("after_reset");
    check("final_left",  audio_left,  16'hBEEF);
    check("final_right", audio_right, 16'hCAFE);

    check("valid_with_err", both_viol, 0);
    check("out_change_without_valid", chg_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule : tb_audio_i2s_rx
